// File: rtl/reverb_pkg.sv
// Shared constants and types for the stereo reverb sequencer.
package reverb_pkg;

    localparam int SAMPLE_WIDTH     = 10;
    localparam int SINGLE_ADC_WIDTH = 16;
    localparam int SINGLE_DAC_WIDTH = 19;
    localparam int ADC_DATA_WIDTH   = 2 * SINGLE_ADC_WIDTH;
    localparam int DAC_DATA_WIDTH   = 2 * SINGLE_DAC_WIDTH;

    localparam logic [SAMPLE_WIDTH-1:0] DEFAULT_DELAY = SAMPLE_WIDTH'(256);

    // Longest a WAIT state may last before the core is declared hung.
    localparam int TIMEOUT_CYCLES = 1023;
    localparam int WDOG_WIDTH     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START_L = 3'd1,
        ST_WAIT_L  = 3'd2,
        ST_START_R = 3'd3,
        ST_WAIT_R  = 3'd4,
        ST_EMIT    = 3'd5
    } seq_state_t;

    // True in the states where a sequence is in flight and a new sample must be dropped.
    function automatic logic in_sequence(input seq_state_t s);
        return (s == ST_START_L) || (s == ST_WAIT_L) ||
               (s == ST_START_R) || (s == ST_WAIT_R);
    endfunction

endpackage

// File: rtl/reverb_wdog.sv
// Watchdog counter: cleared when a core run starts, counts while waiting,
// and flags expiry once the count reaches the limit.
module reverb_wdog
    import reverb_pkg::*;
#(
    parameter int WIDTH = WDOG_WIDTH,
    parameter int LIMIT = TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    // Count waiting cycles; hold at the limit so expiry stays asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT_V);

endmodule

// File: rtl/reverb_seq.sv
// Time-multiplexes one mono reverb core across both halves of a stereo sample.
//
// Handshake: there is no back-pressure anywhere. sample_valid and out_valid are
// single-cycle strobes qualified by ce. The core is driven with a one-cycle
// core_start pulse and answers with a one-cycle core_done pulse; core_out is
// only meaningful while core_done is high. A core that never answers is cut
// off by the watchdog and its result replaced by zero.
module reverb_seq
    import reverb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        sample_valid,
    input  logic [ADC_DATA_WIDTH-1:0]   sample_in,
    input  logic [SAMPLE_WIDTH-1:0]     delay_cfg,
    input  logic                        delay_cfg_we,
    output logic                        core_start,
    output logic [SINGLE_ADC_WIDTH-1:0] core_data,
    output logic [SAMPLE_WIDTH-1:0]     core_delay,
    input  logic                        core_done,
    input  logic [SINGLE_DAC_WIDTH-1:0] core_out,
    output logic                        out_valid,
    output logic [DAC_DATA_WIDTH-1:0]   out_data,
    output logic                        busy,
    output logic                        overrun,
    output logic                        timeout_err
);

    seq_state_t state;
    seq_state_t state_next;

    logic [ADC_DATA_WIDTH-1:0]   sample_q;
    logic [SAMPLE_WIDTH-1:0]     delay_active;
    logic [SAMPLE_WIDTH-1:0]     delay_pending;
    logic [SINGLE_DAC_WIDTH-1:0] left_result;

    logic wdog_clr;
    logic wdog_en;
    logic wdog_expired;
    logic accept;
    logic right_phase;

    // A new sample is only taken when no sequence is in flight.
    assign accept = sample_valid && ((state == ST_IDLE) || (state == ST_EMIT));

    // One watchdog shared by both channels: restarted in each START state.
    assign wdog_clr = ce && ((state == ST_START_L) || (state == ST_START_R));
    assign wdog_en  = ce && ((state == ST_WAIT_L) || (state == ST_WAIT_R));

    reverb_wdog #(
        .WIDTH(WDOG_WIDTH),
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_expired)
    );

    // State register; ce low freezes the sequence in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // Next-state logic; a done pulse wins over a simultaneous watchdog expiry.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (sample_valid) state_next = ST_START_L;
            ST_START_L: state_next = ST_WAIT_L;
            ST_WAIT_L:  if (core_done || wdog_expired) state_next = ST_START_R;
            ST_START_R: state_next = ST_WAIT_R;
            ST_WAIT_R:  if (core_done || wdog_expired) state_next = ST_EMIT;
            ST_EMIT:    state_next = sample_valid ? ST_START_L : ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Datapath: sample latch, delay registers, channel results and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q      <= '0;
            delay_active  <= DEFAULT_DELAY;
            delay_pending <= DEFAULT_DELAY;
            left_result   <= '0;
            out_data      <= '0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else if (ce) begin
            if (delay_cfg_we) begin
                delay_pending <= delay_cfg;
            end
            // Active takes the pending value as it stood before this edge, so a
            // write coinciding with an accepted sample lands on the next one.
            if (accept) begin
                sample_q     <= sample_in;
                delay_active <= delay_pending;
            end
            if (sample_valid && in_sequence(state)) begin
                overrun <= 1'b1;
            end
            if (state == ST_WAIT_L) begin
                if (core_done) begin
                    left_result <= core_out;
                end else if (wdog_expired) begin
                    left_result <= '0;
                    timeout_err <= 1'b1;
                end
            end
            if (state == ST_WAIT_R) begin
                if (core_done) begin
                    out_data <= {left_result, core_out};
                end else if (wdog_expired) begin
                    out_data    <= {left_result, {SINGLE_DAC_WIDTH{1'b0}}};
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    // Core sees the left half until the right-hand run begins.
    assign right_phase = (state == ST_START_R) || (state == ST_WAIT_R) || (state == ST_EMIT);
    assign core_data   = right_phase ? sample_q[SINGLE_ADC_WIDTH-1:0]
                                     : sample_q[ADC_DATA_WIDTH-1:SINGLE_ADC_WIDTH];

    assign core_delay = delay_active;
    assign core_start = ce && ((state == ST_START_L) || (state == ST_START_R));
    assign out_valid  = ce && (state == ST_EMIT);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_reverb_seq.sv
// Directed bench for reverb_seq with a behavioural reverb core (returns input+1).
module tb_reverb_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic [9:0]  delay_cfg = '0;
    logic        delay_cfg_we = 1'b0;
    logic        core_start;
    logic [15:0] core_data;
    logic [9:0]  core_delay;
    logic        core_done = 1'b0;
    logic [18:0] core_out = '0;
    logic        out_valid;
    logic [37:0] out_data;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ov_count = 0;
    int core_lat = 1;   // 0 = core never answers

    logic [37:0] exp_q[$];
    logic [15:0] st_data_q[$];
    int          st_cyc_q[$];

    reverb_seq dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .delay_cfg    (delay_cfg),
        .delay_cfg_we (delay_cfg_we),
        .core_start   (core_start),
        .core_data    (core_data),
        .core_delay   (core_delay),
        .core_done    (core_done),
        .core_out     (core_out),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    // ---------------- core model (clock-enabled like the DUT) ----------------
    int          m_cnt = 0;
    logic        m_act = 1'b0;
    logic [15:0] m_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            core_done <= 1'b0;
        end else if (ce) begin
            if (core_start && core_lat > 0) begin
                m_act  = 1'b1;
                m_cnt  = core_lat;
                m_data = core_data;
            end else if (m_act) begin
                m_cnt = m_cnt - 1;
            end
            if (m_act && m_cnt == 1) begin
                core_done <= 1'b1;
                core_out  <= {3'b000, m_data} + 19'd1;
                m_act = 1'b0;
            end else begin
                core_done <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] exp_word(input logic [31:0] s);
        logic [18:0] l;
        logic [18:0] r;
        l = {3'b000, s[31:16]} + 19'd1;
        r = {3'b000, s[15:0]} + 19'd1;
        return {l, r};
    endfunction

    // Scoreboard and start monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (core_start) begin
            st_data_q.push_back(core_data);
            st_cyc_q.push_back(cyc);
        end
        if (out_valid) begin
            ov_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic pulse_sample(input logic [31:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Drives a sample in cycle 0 (t0 = its cycle stamp); returns in cycle 1.
    task automatic send(input logic [31:0] s, input logic we, input logic [9:0] cfg, output int t0);
        @(negedge clk);
        t0           = cyc;
        delay_cfg_we = we;
        delay_cfg    = cfg;
        pulse_sample(s);
        delay_cfg_we = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int t0, input int budget, input int exp_rel);
        int rel;
        rel = -1;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                rel = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check(tag, 64'(rel), 64'(exp_rel));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int ovc;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_core_data", 64'(core_data), 64'd0);
        check("rst_core_delay", 64'(core_delay), 64'd256);
        check("rst_start", 64'(core_start), 64'd0);

        // Basic sequence, core answers after one cycle
        core_lat = 1;
        st_data_q.delete();
        st_cyc_q.delete();
        exp_q.push_back({19'h01235, 19'h0ABCE});
        send(32'h1234_ABCD, 1'b0, 10'd0, t0);
        check("basic_busy", 64'(busy), 64'd1);
        wait_out("basic_latency", t0, 20, 5);
        check("basic_starts", 64'(st_data_q.size()), 64'd2);
        if (st_data_q.size() == 2) begin
            check("basic_left_data", 64'(st_data_q[0]), 64'h1234);
            check("basic_right_data", 64'(st_data_q[1]), 64'hABCD);
            check("basic_left_cyc", 64'(st_cyc_q[0] - t0), 64'd1);
            check("basic_right_cyc", 64'(st_cyc_q[1] - t0), 64'd3);
        end
        @(negedge clk);
        check("basic_idle", 64'(busy), 64'd0);

        // Overrun: second sample during WAIT_L is dropped
        core_lat = 3;
        ovc = ov_count;
        exp_q.push_back(exp_word(32'h0F0F_7001));
        send(32'h0F0F_7001, 1'b0, 10'd0, t0);
        @(negedge clk);
        pulse_sample(32'hDEAD_BEEF);
        check("ovr_flag", 64'(overrun), 64'd1);
        wait_out("ovr_latency", t0, 40, 9);
        repeat (15) @(negedge clk);
        check("ovr_one_output", 64'(ov_count - ovc), 64'd1);
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Delay written during WAIT_R takes effect on the next sample
        core_lat = 1;
        exp_q.push_back(exp_word(32'h0001_0002));
        send(32'h0001_0002, 1'b0, 10'd0, t0);
        repeat (3) @(negedge clk);
        delay_cfg    = 10'd100;
        delay_cfg_we = 1'b1;
        @(negedge clk);
        delay_cfg_we = 1'b0;
        check("dly_hold_in_seq", 64'(core_delay), 64'd256);
        wait_out("dly_latency_a", t0, 20, 5);
        @(negedge clk);
        check("dly_hold_idle", 64'(core_delay), 64'd256);
        exp_q.push_back(exp_word(32'h7FFF_8000));
        send(32'h7FFF_8000, 1'b0, 10'd0, t0);
        check("dly_applied", 64'(core_delay), 64'd100);
        wait_out("dly_latency_b", t0, 20, 5);
        // Same-cycle write does not reach the sample it coincides with
        exp_q.push_back(exp_word(32'hFFFF_FFFF));
        send(32'hFFFF_FFFF, 1'b1, 10'd200, t0);
        check("dly_same_cycle", 64'(core_delay), 64'd100);
        wait_out("dly_latency_c", t0, 20, 5);
        exp_q.push_back(exp_word(32'h0000_0000));
        send(32'h0000_0000, 1'b0, 10'd0, t0);
        check("dly_next_sample", 64'(core_delay), 64'd200);
        wait_out("dly_latency_d", t0, 20, 5);

        // Hung core: both channels time out
        core_lat = 0;
        st_data_q.delete();
        st_cyc_q.delete();
        exp_q.push_back(38'h0);
        send(32'h5555_AAAA, 1'b0, 10'd0, t0);
        check("to_flag_clear", 64'(timeout_err), 64'd0);
        wait_out("to_latency", t0, 2200, 2051);
        check("to_flag_set", 64'(timeout_err), 64'd1);
        check("to_starts", 64'(st_cyc_q.size()), 64'd2);
        if (st_cyc_q.size() == 2) begin
            check("to_right_start_cyc", 64'(st_cyc_q[1] - t0), 64'd1026);
        end

        // Reset in WAIT_R aborts the sequence and clears everything
        core_lat = 5;
        send(32'h1111_2222, 1'b1, 10'd50, t0);
        pulse_sample(32'h3333_4444);
        check("abort_overrun", 64'(overrun), 64'd1);
        check("abort_delay_before", 64'(core_delay), 64'd200);
        repeat (6) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        check("abort_timeout_before", 64'(timeout_err), 64'd1);
        ovc = ov_count;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_overrun_clr", 64'(overrun), 64'd0);
        check("abort_timeout_clr", 64'(timeout_err), 64'd0);
        check("abort_core_delay", 64'(core_delay), 64'd256);
        check("abort_out_data", 64'(out_data), 64'd0);
        repeat (20) @(negedge clk);
        check("abort_no_output", 64'(ov_count - ovc), 64'd0);

        // Clock enable held low for 10 cycles inside WAIT_L
        core_lat = 4;
        exp_q.push_back(exp_word(32'hA5A5_5A5A));
        send(32'hA5A5_5A5A, 1'b0, 10'd0, t0);
        check("ce_pending_reset", 64'(core_delay), 64'd256);
        repeat (2) @(negedge clk);
        ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                sample_valid = 1'b1;
                sample_in    = 32'h9999_9999;
            end
            if (i == 3) begin
                sample_valid = 1'b0;
                delay_cfg    = 10'd77;
                delay_cfg_we = 1'b1;
            end
            if (i == 4) delay_cfg_we = 1'b0;
            if (i == 5) begin
                check("ce_busy_held", 64'(busy), 64'd1);
                check("ce_no_start", 64'(core_start), 64'd0);
            end
            @(negedge clk);
        end
        ce = 1'b1;
        wait_out("ce_latency", t0, 60, 21);
        check("ce_no_overrun", 64'(overrun), 64'd0);
        core_lat = 1;
        exp_q.push_back(exp_word(32'h0102_0304));
        send(32'h0102_0304, 1'b0, 10'd0, t0);
        check("ce_cfg_ignored", 64'(core_delay), 64'd256);
        wait_out("ce_latency_after", t0, 20, 5);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
